// File: rtl/switch_conditioner_pkg.sv
// Shared constants and types for the switch conditioner.
// Debounce defaults for hardware (20 ms at 50 MHz) and simulation.
package switch_cond_pkg;

   localparam int SW_COUNT_DEFAULT    = 4;
   localparam int DEBOUNCE_50MHZ_20MS = 1000000;
   localparam int DEBOUNCE_SIM        = 8;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'd0,
      EDGE_RISE = 2'd1,
      EDGE_FALL = 2'd2
   } edge_e;

   function automatic int cnt_width(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// Switch bundle between board pins, the conditioner and the HPS PIO.
// The conditioner is the slave; the board/HPS side is the master.
interface switch_conditioner_if #(
   parameter int NUM_SW = 4
);

   logic [NUM_SW-1:0] sw_raw;
   logic [NUM_SW-1:0] evt_clr;
   logic [NUM_SW-1:0] sw_stable;
   logic [NUM_SW-1:0] sw_rise;
   logic [NUM_SW-1:0] sw_fall;
   logic              sw_changed;
   logic [NUM_SW-1:0] evt_sticky;

   modport master (
      output sw_raw,
      output evt_clr,
      input  sw_stable,
      input  sw_rise,
      input  sw_fall,
      input  sw_changed,
      input  evt_sticky
   );

   modport slave (
      input  sw_raw,
      input  evt_clr,
      output sw_stable,
      output sw_rise,
      output sw_fall,
      output sw_changed,
      output evt_sticky
   );

endinterface

// File: rtl/switch_conditioner_debounce_bit.sv
// One switch bit: 2-flop synchronizer, hold counter, stable level
// and registered rise/fall pulses. Polarity is applied by the parent.
module debounce_bit
   import switch_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
   parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_sync,
   input  logic i_syn,
   output logic o_stable,
   output logic o_rise,
   output logic o_fall,
   output logic o_rise_nxt,
   output logic o_fall_nxt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_stable;
   logic             r_rise;
   logic             r_fall;

   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_stable_nxt;
   edge_e            w_edge;
   logic             w_rise_nxt;
   logic             w_fall_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
      end
   end

   // Any agreement with the stable level discards the partial count.
   always_comb begin
      w_cnt_nxt    = '0;
      w_stable_nxt = r_stable;
      w_edge       = EDGE_NONE;
      if (i_syn != r_stable) begin
         if (r_cnt == CNT_LAST) begin
            w_stable_nxt = i_syn;
            w_edge       = i_syn ? EDGE_RISE : EDGE_FALL;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_rise_nxt = 1'b0;
      w_fall_nxt = 1'b0;
      unique case (w_edge)
         EDGE_RISE: w_rise_nxt = 1'b1;
         EDGE_FALL: w_fall_nxt = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_stable <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_stable <= w_stable_nxt;
         r_rise   <= w_rise_nxt;
         r_fall   <= w_fall_nxt;
      end
   end

   assign o_sync     = r_s2;
   assign o_stable   = r_stable;
   assign o_rise     = r_rise;
   assign o_fall     = r_fall;
   assign o_rise_nxt = w_rise_nxt;
   assign o_fall_nxt = w_fall_nxt;

endmodule

// File: rtl/switch_conditioner.sv
// Slide-switch conditioner in front of the switch PIO: per-bit debounce,
// edge pulses, a combined change flag and HPS-clearable sticky events.
module switch_conditioner
   import switch_cond_pkg::*;
#(
   parameter  int NUM_SW          = SW_COUNT_DEFAULT,
   parameter  int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_20MS,
   parameter  int INVERT_IN       = 0,
   localparam int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   switch_conditioner_if.slave  sw_if
);

   logic [NUM_SW-1:0] w_sync;
   logic [NUM_SW-1:0] w_syn;
   logic [NUM_SW-1:0] w_stable;
   logic [NUM_SW-1:0] w_rise;
   logic [NUM_SW-1:0] w_fall;
   logic [NUM_SW-1:0] w_rise_nxt;
   logic [NUM_SW-1:0] w_fall_nxt;

   logic              r_changed;
   logic [NUM_SW-1:0] r_sticky;

   assign w_syn = (INVERT_IN != 0) ? ~w_sync : w_sync;

   for (genvar g = 0; g < NUM_SW; g++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_db (
         .clk        (clk_clk),
         .rst_n      (reset_reset_n),
         .i_raw      (sw_if.sw_raw[g]),
         .o_sync     (w_sync[g]),
         .i_syn      (w_syn[g]),
         .o_stable   (w_stable[g]),
         .o_rise     (w_rise[g]),
         .o_fall     (w_fall[g]),
         .o_rise_nxt (w_rise_nxt[g]),
         .o_fall_nxt (w_fall_nxt[g])
      );
   end

   // Sticky latches the visible pulse, so a clear during the pulse loses.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_changed <= 1'b0;
         r_sticky  <= '0;
      end else begin
         r_changed <= |(w_rise_nxt | w_fall_nxt);
         r_sticky  <= w_rise | w_fall | (r_sticky & ~sw_if.evt_clr);
      end
   end

   assign sw_if.sw_stable  = w_stable;
   assign sw_if.sw_rise    = w_rise;
   assign sw_if.sw_fall    = w_fall;
   assign sw_if.sw_changed = r_changed;
   assign sw_if.evt_sticky = r_sticky;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: two DUTs (plain and inverted input)
// against a sample-window reference model, directed plus random stimulus.
module tb_switch_conditioner;
   import switch_cond_pkg::*;

   localparam int N = 4;
   localparam int D = DEBOUNCE_SIM;
   localparam int HMAX = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   switch_conditioner_if #(.NUM_SW(N)) if0 ();
   switch_conditioner_if #(.NUM_SW(N)) if1 ();

   switch_conditioner #(
      .NUM_SW          (N),
      .DEBOUNCE_CYCLES (D),
      .INVERT_IN       (0)
   ) dut0 (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .sw_if         (if0)
   );

   switch_conditioner #(
      .NUM_SW          (N),
      .DEBOUNCE_CYCLES (D),
      .INVERT_IN       (1)
   ) dut1 (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .sw_if         (if1)
   );

   // Model: a level is accepted once the last D synchronized samples
   // (raw delayed by two edges) all disagree with the current level.
   logic [N-1:0] hist [2][HMAX];
   int           n_edge;
   logic [N-1:0] m_stable [2];
   logic [N-1:0] m_rise   [2];
   logic [N-1:0] m_fall   [2];
   logic [N-1:0] m_sticky [2];
   logic         m_chg    [2];

   function automatic logic win_all(int d, int b, int t, logic v);
      logic s;
      for (int k = t - D - 1; k <= t - 2; k++) begin
         if (k < -1 || k > HMAX) return 1'b0;
         if (k <= 0) s = (d == 1);
         else        s = hist[d][k-1][b] ^ (d == 1);
         if (s != v) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_update();
      logic [N-1:0] clr;
      if (!rst_n) begin
         n_edge = 0;
         for (int d = 0; d < 2; d++) begin
            m_stable[d] = '0;
            m_rise[d]   = '0;
            m_fall[d]   = '0;
            m_sticky[d] = '0;
            m_chg[d]    = 1'b0;
         end
      end else begin
         n_edge++;
         if (n_edge <= HMAX) begin
            hist[0][n_edge-1] = if0.sw_raw;
            hist[1][n_edge-1] = if1.sw_raw;
         end
         for (int d = 0; d < 2; d++) begin
            clr = (d == 0) ? if0.evt_clr : if1.evt_clr;
            m_sticky[d] = m_rise[d] | m_fall[d] | (m_sticky[d] & ~clr);
            m_rise[d] = '0;
            m_fall[d] = '0;
            for (int b = 0; b < N; b++) begin
               if (win_all(d, b, n_edge, ~m_stable[d][b])) begin
                  m_stable[d][b] = ~m_stable[d][b];
                  if (m_stable[d][b]) m_rise[d][b] = 1'b1;
                  else                m_fall[d][b] = 1'b1;
               end
            end
            m_chg[d] = |(m_rise[d] | m_fall[d]);
         end
      end
   endtask

   initial begin
      n_edge = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         model_update();
      end
   end

   function automatic logic [4*N:0] obs(int d);
      if (d == 0)
         return {if0.sw_stable, if0.sw_rise, if0.sw_fall,
                 if0.sw_changed, if0.evt_sticky};
      return {if1.sw_stable, if1.sw_rise, if1.sw_fall,
              if1.sw_changed, if1.evt_sticky};
   endfunction

   function automatic logic [4*N:0] expv(int d);
      return {m_stable[d], m_rise[d], m_fall[d], m_chg[d], m_sticky[d]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic [N-1:0] r0, logic [N-1:0] r1,
                        logic [N-1:0] c0, logic [N-1:0] c1);
      if0.sw_raw  = r0;
      if1.sw_raw  = r1;
      if0.evt_clr = c0;
      if1.evt_clr = c1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive('0, '0, '0, '0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive('0, '0, '0, '0);
      step();
      step();
      checks++;
      if (obs(0) !== '0) begin
         errors++;
         $display("FAIL reset_hold got %h exp 0", obs(0));
      end
      rst_n = 1'b1;
      for (int s = 1; s <= 20; s++) begin
         step();
         checks++;
         if (obs(0) !== '0) begin
            errors++;
            $display("FAIL reset_idle cyc%0d got %h exp 0", s, obs(0));
         end
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== expv(d)) begin
               errors++;
               $display("FAIL reset_model dut%0d got %h exp %h",
                        d, obs(d), expv(d));
            end
         end
      end
   endtask

   task automatic test_rise();
      do_reset();
      drive(4'b0001, '0, '0, '0);
      for (int e = 0; e <= 10; e++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== expv(d)) begin
               errors++;
               $display("FAIL rise_model dut%0d E%0d got %h exp %h",
                        d, e, obs(d), expv(d));
            end
         end
         if (e == 8) begin
            checks++;
            if (if0.sw_stable !== 4'b0000) begin
               errors++;
               $display("FAIL rise_early got %b exp 0000", if0.sw_stable);
            end
         end
         if (e == 9) begin
            checks++;
            if ({if0.sw_stable, if0.sw_rise, if0.sw_changed}
                !== {4'b0001, 4'b0001, 1'b1}) begin
               errors++;
               $display("FAIL rise_E9 got %b/%b/%b exp 0001/0001/1",
                        if0.sw_stable, if0.sw_rise, if0.sw_changed);
            end
         end
         if (e == 10) begin
            checks++;
            if ({if0.sw_rise, if0.sw_changed, if0.evt_sticky}
                !== {4'b0000, 1'b0, 4'b0001}) begin
               errors++;
               $display("FAIL rise_E10 got %b/%b/%b exp 0000/0/0001",
                        if0.sw_rise, if0.sw_changed, if0.evt_sticky);
            end
         end
      end
   endtask

   task automatic test_glitch();
      int pulses = 0;
      int rise_at = -1;
      int fall_at = -1;
      logic [N-1:0] fall_val = '0;
      do_reset();
      for (int s = 0; s < 22; s++) begin
         drive((s < 7) ? 4'b0100 : 4'b0000, '0, '0, '0);
         step();
         if (if0.sw_rise[2] || if0.sw_fall[2]) pulses++;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== expv(d)) begin
               errors++;
               $display("FAIL glitch_model dut%0d got %h exp %h",
                        d, obs(d), expv(d));
            end
         end
      end
      checks++;
      if (pulses != 0 || if0.sw_stable[2] !== 1'b0) begin
         errors++;
         $display("FAIL glitch_reject pulses %0d stable %b exp 0/0",
                  pulses, if0.sw_stable[2]);
      end
      for (int s = 0; s < 30; s++) begin
         drive((s < 8) ? 4'b0100 : 4'b0000, '0, '0, '0);
         step();
         if (if0.sw_rise[2] && rise_at < 0) rise_at = s + 1;
         if (if0.sw_fall[2] && fall_at < 0) begin
            fall_at  = s + 1;
            fall_val = if0.sw_fall;
         end
      end
      checks++;
      if (rise_at != 10) begin
         errors++;
         $display("FAIL accept8_rise at %0d exp 10", rise_at);
      end
      checks++;
      if (fall_at != 18 || fall_val !== 4'b0100) begin
         errors++;
         $display("FAIL accept8_fall at %0d val %b exp 18/0100",
                  fall_at, fall_val);
      end
   endtask

   task automatic test_simul();
      int n_rise = 0;
      int n_chg = 0;
      int at = -1;
      do_reset();
      drive(4'b1010, '0, '0, '0);
      for (int s = 1; s <= 14; s++) begin
         step();
         if (if0.sw_rise === 4'b1010) begin
            n_rise++;
            at = s;
         end
         if (if0.sw_changed === 1'b1) n_chg++;
      end
      checks++;
      if (n_rise != 1 || n_chg != 1 || at != 10) begin
         errors++;
         $display("FAIL simul rise %0d chg %0d at %0d exp 1/1/10",
                  n_rise, n_chg, at);
      end
   endtask

   task automatic test_clr();
      int found = 0;
      do_reset();
      drive(4'b0010, '0, '0, '0);
      for (int s = 0; s < 20 && found == 0; s++) begin
         step();
         if (if0.sw_rise[1] === 1'b1) found = 1;
      end
      checks++;
      if (found == 0) begin
         errors++;
         $display("FAIL clr_wait got no rise exp rise within 20");
      end
      drive(4'b0010, '0, 4'b0010, '0);
      step();
      checks++;
      if (if0.evt_sticky[1] !== 1'b1) begin
         errors++;
         $display("FAIL clr_set_wins got %b exp 1", if0.evt_sticky[1]);
      end
      step();
      checks++;
      if (if0.evt_sticky[1] !== 1'b0) begin
         errors++;
         $display("FAIL clr_clear got %b exp 0", if0.evt_sticky[1]);
      end
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs(d) !== expv(d)) begin
            errors++;
            $display("FAIL clr_model dut%0d got %h exp %h",
                     d, obs(d), expv(d));
         end
      end
      drive(4'b0010, '0, '0, '0);
   endtask

   task automatic test_reset_mid();
      int rise_at = -1;
      int inv_bad = 0;
      logic [N-1:0] rise_val = '0;
      do_reset();
      drive(4'b0001, 4'b1111, '0, '0);
      repeat (12) step();
      drive(4'b1001, 4'b1111, '0, '0);
      repeat (7) step();
      rst_n = 1'b0;
      #1;
      checks++;
      if (if0.sw_stable !== 4'b0000 || if0.evt_sticky !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_clear got %b/%b exp 0000/0000",
                  if0.sw_stable, if0.evt_sticky);
      end
      step();
      step();
      rst_n = 1'b1;
      for (int s = 1; s <= 30; s++) begin
         step();
         if (if0.sw_rise[3] && rise_at < 0) begin
            rise_at  = s;
            rise_val = if0.sw_rise;
         end
         if (if1.sw_stable !== 4'b0000) inv_bad++;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== expv(d)) begin
               errors++;
               $display("FAIL rstmid_model dut%0d got %h exp %h",
                        d, obs(d), expv(d));
            end
         end
      end
      checks++;
      if (rise_at != 10 || rise_val !== 4'b1001) begin
         errors++;
         $display("FAIL rstmid_rise at %0d val %b exp 10/1001",
                  rise_at, rise_val);
      end
      checks++;
      if (inv_bad != 0) begin
         errors++;
         $display("FAIL invert_hold got %0d nonzero cycles exp 0", inv_bad);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r0;
      logic [N-1:0] r1;
      int hold;
      int cyc = 0;
      do_reset();
      while (cyc < 900) begin
         r0   = N'($urandom);
         r1   = N'($urandom);
         hold = $urandom_range(1, 12);
         for (int h = 0; h < hold; h++) begin
            drive(r0, r1,
                  N'($urandom & $urandom),
                  N'($urandom & $urandom));
            if (cyc == 450) begin
               rst_n = 1'b0;
               #2;
               rst_n = 1'b1;
            end
            step();
            cyc++;
            for (int d = 0; d < 2; d++) begin
               checks++;
               if (obs(d) !== expv(d)) begin
                  errors++;
                  $display("FAIL random dut%0d cyc%0d got %h exp %h",
                           d, cyc, obs(d), expv(d));
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      drive('0, '0, '0, '0);
      test_reset();
      test_rise();
      test_glitch();
      test_simul();
      test_clr();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Conditions the raw slide-switch inputs before they reach the platform switch PIO (pio_switches_0_external_connection_export, 4 bits).
- Per bit: 2-flop synchronization, counter-based debounce, and one-cycle rise/fall event pulses.
- A sticky event register lets the HPS poll for missed changes and clear them.
- Sits between the board switch pins and the platform instance in the top level.

Parameters:
- NUM_SW, 4, number of switch bits; must equal the PIO switch width.
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized level must hold before it is accepted (20 ms at 50 MHz); legal range is >= 2.
- INVERT_IN, 0, if 1 each raw bit is inverted after synchronization (for active-low keys).
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width; derived, not overridden.

Ports:
- clk_clk  in  1  system clock (50 MHz).
- reset_reset_n  in  1  asynchronous active-low reset.
- sw_raw  in  NUM_SW  asynchronous switch pins.
- sw_stable  out  NUM_SW  debounced level; drives pio_switches_0_external_connection_export.
- sw_rise  out  NUM_SW  one-cycle pulse per bit when sw_stable goes 0->1.
- sw_fall  out  NUM_SW  one-cycle pulse per bit when sw_stable goes 1->0.
- sw_changed  out  1  OR of all sw_rise and sw_fall bits in the same cycle.
- evt_sticky  out  NUM_SW  per-bit latched "changed since last clear".
- evt_clr  in  NUM_SW  per-bit clear for evt_sticky, synchronous to clk_clk.

Behaviour:
- Reset (asynchronous assert, removal synchronous to clk_clk) clears all registers to 0:
  - sync flops, counters, sw_stable, sw_rise, sw_fall, sw_changed, evt_sticky.
- Synchronizer: s1 <= sw_raw, s2 <= s1. After s2, apply INVERT_IN to form syn.
- Per-bit debounce; registered state per bit is cnt[CNT_W-1:0] and stable.
  - If syn == stable: cnt <= 0 and no pulse.
  - If syn != stable and cnt == DEBOUNCE_CYCLES-1: stable <= syn, cnt <= 0, and assert the rise or fall pulse for exactly one cycle.
  - If syn != stable otherwise: cnt <= cnt + 1.
- Latency: a raw change set up before edge E0 is captured in s1 at E0 and in s2 at E1. sw_stable and the pulse update at edge E0+DEBOUNCE_CYCLES+1.
- Glitch rejection: any return of syn to the stable value before the count completes resets cnt to 0. There is no partial credit, and sw_stable must not change.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1, so no wrap can occur.
- Pulses are registered outputs, high for one cycle only. sw_rise and sw_fall are never both high on the same bit.
- sw_changed is registered in the same cycle as the pulses (it is the OR of the next-state pulses).
- evt_sticky[i] per cycle:
  - Set when the bit-i pulse fires.
  - Else cleared when evt_clr[i] = 1.
  - Set wins over a simultaneous clear.
  - evt_clr on an already clear bit has no effect.
- Reset mid-count: the count is abandoned and sw_stable returns to 0. If a switch is held at 1 through reset, it re-debounces after reset and produces a sw_rise, which is intended.
- Bits are fully independent. Simultaneous changes on several bits produce simultaneous pulses and a single sw_changed cycle.

Decomposition:
- Package switch_cond_pkg holds:
  - SW_COUNT_DEFAULT = 4.
  - DEBOUNCE_50MHZ_20MS = 1000000.
  - DEBOUNCE_SIM = 8.
- One natural sub-module, debounce_bit: synchronizer, counter, stable register and pulse generation for one bit.
  - It is instantiated NUM_SW times by a generate loop.
  - The top module adds inversion, sw_changed and the sticky/clear logic.

Test Plan (DEBOUNCE_CYCLES=8 unless noted):
- Reset release with sw_raw=0000 held -> all outputs 0 for 20 cycles, no pulses.
- sw_raw[0] 0->1 before edge E0 and held -> sw_stable=0001 and sw_rise=0001 exactly at E9; pulse gone at E10; sw_changed=1 only at E9; evt_sticky=0001.
- sw_raw[2] pulses high for 7 cycles, then low -> sw_stable unchanged and no pulse. Pulse high for 8 cycles -> accepted; then a fall after 8 further low cycles gives sw_fall=0100.
- sw_raw 0000->1010 simultaneously -> one cycle with sw_rise=1010 and sw_changed=1.
- evt_clr[1]=1 in the same cycle a bit-1 pulse fires -> evt_sticky[1] stays 1. evt_clr[1] next cycle -> evt_sticky[1]=0.
- reset_reset_n low at cnt=5 with sw_raw[3] held 1, then released -> sw_stable=0000 immediately; sw_rise[3] fires 9 edges after the first post-reset edge. Repeat with INVERT_IN=1 and sw_raw=1111 -> sw_stable stays 0000.
